// File: rtl/fpu_issue.sv
// fpu_issue: request FIFO and one-at-a-time sequencer in front of the non-resettable fpu.
// Optional WAIT watchdog is compiled in when FPU_TIMEOUT_EN is defined.
module fpu_issue #(
    parameter int DEPTH   = 2,
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [4:0]  req_op,
    input  logic [3:0]  req_rd,
    input  logic [15:0] req_a,
    input  logic [15:0] req_b,
    output logic        fpu_en,
    output logic [4:0]  fpu_instr,
    output logic [15:0] fpu_op1,
    output logic [15:0] fpu_op2,
    input  logic [15:0] fpu_result,
    input  logic        fpu_done,
    output logic        wb_valid,
    input  logic        wb_ready,
    output logic [3:0]  wb_rd,
    output logic [15:0] wb_data,
    output logic        wb_err,
    output logic        busy
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [4:0] OPFTOI = 5'h12;

    typedef enum logic [2:0] {S_FLUSH, S_IDLE, S_LAUNCH, S_WAIT, S_HOLD} state_t;

    logic [4:0]  fifo_op   [DEPTH];
    logic [3:0]  fifo_rd   [DEPTH];
    logic [15:0] fifo_a    [DEPTH];
    logic [15:0] fifo_b    [DEPTH];

    state_t        state_q, state_d;
    logic [1:0]    flush_cnt_q, flush_cnt_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [4:0]    op_q, op_d;
    logic [3:0]    rd_q, rd_d;
    logic [15:0]   a_q, a_d, b_q, b_d;
    logic [15:0]   wb_data_q, wb_data_d;
    logic [3:0]    wb_rd_q, wb_rd_d;
    logic          wb_err_q, wb_err_d;
    logic          push, pop, empty, full, head_legal;
`ifdef FPU_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic          tmo_flush_q, tmo_flush_d;
`endif

    assign empty      = (count_q == '0);
    assign full       = (count_q == CW'(DEPTH));
    assign req_ready  = !reset && !full;
    assign push       = req_valid && req_ready;
    assign head_legal = (fifo_op[rd_ptr_q] >= 5'h11) && (fifo_op[rd_ptr_q] <= 5'h16);

    assign wb_valid  = (state_q == S_HOLD);
    assign wb_rd     = wb_rd_q;
    assign wb_data   = wb_data_q;
    assign wb_err    = wb_err_q;
    assign busy      = !empty || (state_q != S_IDLE);
    assign fpu_instr = (state_q == S_FLUSH) ? OPFTOI : op_q;
    assign fpu_op1   = (state_q == S_FLUSH) ? 16'h0 : a_q;
    assign fpu_op2   = (state_q == S_FLUSH) ? 16'h0 : b_q;

    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        op_d        = op_q;
        rd_d        = rd_q;
        a_d         = a_q;
        b_d         = b_q;
        wb_data_d   = wb_data_q;
        wb_rd_d     = wb_rd_q;
        wb_err_d    = wb_err_q;
        pop         = 1'b0;
        fpu_en      = 1'b0;
`ifdef FPU_TIMEOUT_EN
        tmo_cnt_d   = tmo_cnt_q;
        tmo_flush_d = tmo_flush_q;
`endif
        case (state_q)
            S_FLUSH: begin
                fpu_en      = 1'b1;
                flush_cnt_d = flush_cnt_q + 2'd1;
                if (flush_cnt_q == 2'd2) begin
                    flush_cnt_d = 2'd0;
                    state_d     = S_IDLE;
                end
            end
            S_IDLE: pop = !empty;
            S_LAUNCH: begin
                // done may still be high from the previous operation; ignore it here
                fpu_en  = 1'b1;
                state_d = S_WAIT;
`ifdef FPU_TIMEOUT_EN
                tmo_cnt_d = '0;
`endif
            end
            S_WAIT: begin
                fpu_en = !fpu_done;
                if (fpu_done) begin
                    wb_data_d = fpu_result;
                    wb_err_d  = 1'b0;
                    wb_rd_d   = rd_q;
                    state_d   = S_HOLD;
                end
`ifdef FPU_TIMEOUT_EN
                else if (tmo_cnt_q == TW'(TIMEOUT - 1)) begin
                    fpu_en      = 1'b0;
                    wb_data_d   = 16'h0;
                    wb_err_d    = 1'b1;
                    wb_rd_d     = rd_q;
                    tmo_flush_d = 1'b1;
                    state_d     = S_HOLD;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end
`endif
            end
            S_HOLD: begin
                if (wb_ready) begin
`ifdef FPU_TIMEOUT_EN
                    // a hung fpu must be walked back to its start state before reuse
                    if (tmo_flush_q) begin
                        tmo_flush_d = 1'b0;
                        state_d     = S_FLUSH;
                    end else if (!empty) begin
                        pop = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
`else
                    if (!empty) pop = 1'b1;
                    else        state_d = S_IDLE;
`endif
                end
            end
            default: state_d = S_FLUSH;
        endcase

        if (pop) begin
            op_d = fifo_op[rd_ptr_q];
            rd_d = fifo_rd[rd_ptr_q];
            a_d  = fifo_a[rd_ptr_q];
            b_d  = fifo_b[rd_ptr_q];
            if (head_legal) begin
                state_d = S_LAUNCH;
            end else begin
                wb_data_d = 16'h0;
                wb_err_d  = 1'b1;
                wb_rd_d   = fifo_rd[rd_ptr_q];
                state_d   = S_HOLD;
            end
        end

        wr_ptr_d = wr_ptr_q + AW'(push);
        rd_ptr_d = rd_ptr_q + AW'(pop);
        count_d  = count_q + CW'(push) - CW'(pop);

        if (reset) fpu_en = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_op[wr_ptr_q] <= req_op;
            fifo_rd[wr_ptr_q] <= req_rd;
            fifo_a[wr_ptr_q]  <= req_a;
            fifo_b[wr_ptr_q]  <= req_b;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_FLUSH;
            flush_cnt_q <= 2'd0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            op_q        <= 5'h0;
            rd_q        <= 4'h0;
            a_q         <= 16'h0;
            b_q         <= 16'h0;
            wb_data_q   <= 16'h0;
            wb_rd_q     <= 4'h0;
            wb_err_q    <= 1'b0;
`ifdef FPU_TIMEOUT_EN
            tmo_cnt_q   <= '0;
            tmo_flush_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            op_q        <= op_d;
            rd_q        <= rd_d;
            a_q         <= a_d;
            b_q         <= b_d;
            wb_data_q   <= wb_data_d;
            wb_rd_q     <= wb_rd_d;
            wb_err_q    <= wb_err_d;
`ifdef FPU_TIMEOUT_EN
            tmo_cnt_q   <= tmo_cnt_d;
            tmo_flush_q <= tmo_flush_d;
`endif
        end
    end
endmodule

// File: tb/tb_fpu_issue.sv
// Bench for fpu_issue: behavioural fpu stand-in plus in-order result reference queue.
module tb_fpu_issue;
    localparam logic [4:0] OPITOF = 5'h11;
    localparam logic [4:0] OPFTOI = 5'h12;
    localparam logic [4:0] OPMULF = 5'h15;
    localparam logic [4:0] OPADD  = 5'h08;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0, req_ready;
    logic [4:0]  req_op = 5'h0;
    logic [3:0]  req_rd = 4'h0;
    logic [15:0] req_a = 16'h0, req_b = 16'h0;
    logic        fpu_en;
    logic [4:0]  fpu_instr;
    logic [15:0] fpu_op1, fpu_op2;
    logic [15:0] fpu_result = 16'h5a5a;
    logic        fpu_done = 1'b1;
    logic        wb_valid, wb_ready = 1'b0;
    logic [3:0]  wb_rd;
    logic [15:0] wb_data;
    logic        wb_err, busy;

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;

    typedef struct {
        logic [3:0]  rd;
        logic [15:0] data;
        logic        err;
    } exp_t;
    exp_t exp_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fpu_issue #(.DEPTH(2), .TIMEOUT(8)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_rd(req_rd),
        .req_a(req_a), .req_b(req_b),
        .fpu_en(fpu_en), .fpu_instr(fpu_instr), .fpu_op1(fpu_op1), .fpu_op2(fpu_op2),
        .fpu_result(fpu_result), .fpu_done(fpu_done),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_data(wb_data),
        .wb_err(wb_err), .busy(busy)
    );

    // signed 16-bit integer to bfloat16 (top half of the float32 encoding, truncated)
    function automatic logic [15:0] itof(input logic [15:0] v);
        int mag;
        int e;
        logic s;
        logic [6:0] m;
        logic [7:0] ex;
        if (v == 16'h0) return 16'h0;
        s   = v[15];
        mag = s ? (65536 - int'(v)) : int'(v);
        e   = 0;
        while ((mag >> (e + 1)) != 0) e++;
        if (e >= 7) m = 7'((mag >> (e - 7)) & 127);
        else        m = 7'((mag << (7 - e)) & 127);
        ex = 8'(127 + e);
        return {s, ex, m};
    endfunction

    // fpu stand-in: no reset, 3 enabled edges per op, 1 edge when op2 is zero,
    // MULF hangs until an FTOI is issued; done is sticky (stale) until the next launch
    int          m_step = $urandom_range(0, 2);
    bit          m_hang = 1'b0;
    logic [4:0]  m_op = OPITOF;
    logic [15:0] m_b = 16'h1;
    int          itof_en_edges = 0;
    int          other_en_edges = 0;

    always @(posedge clk) begin
        if (fpu_en) begin
            if (fpu_instr == OPITOF) itof_en_edges++;
            else if (fpu_instr != OPFTOI) other_en_edges++;
            if (m_hang) begin
                if (fpu_instr == OPFTOI) begin
                    m_hang <= 1'b0;
                    m_step <= 0;
                end
            end else if (m_step == 0) begin
                m_op <= fpu_instr;
                m_b  <= fpu_op2;
                if (fpu_instr == OPMULF) begin
                    m_hang   <= 1'b1;
                    fpu_done <= 1'b0;
                end else if (fpu_op2 == 16'h0) begin
                    fpu_result <= 16'h0;
                    fpu_done   <= 1'b1;
                end else begin
                    m_step   <= 1;
                    fpu_done <= 1'b0;
                end
            end else if (m_step == 1) begin
                m_step <= 2;
            end else begin
                m_step     <= 0;
                fpu_done   <= 1'b1;
                fpu_result <= (m_op == OPITOF) ? itof(m_b) : 16'h0;
            end
        end
    end

    // Drives one request; starts and ends just after a rising edge
    task automatic push(input logic [4:0] op, input logic [3:0] rd, input logic [15:0] a,
                        input logic [15:0] b, output int t_acc);
        bit rdy;
        bit got;
        got = 1'b0;
        t_acc = -1;
        req_valid = 1'b1; req_op = op; req_rd = rd; req_a = a; req_b = b;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            rdy = req_ready;
            @(posedge clk);
            #1;
            if (rdy) begin
                got = 1'b1;
                t_acc = cyc;
            end
        end
        req_valid = 1'b0;
        if (!got) begin
            n_checks++; n_fail++;
            $display("FAIL push_accept: op %h not accepted, required within 200 cycles", op);
        end
    endtask

    // Waits for wb_valid, records payload and latency from t0, then handshakes once
    task automatic get_result(input int t0, output logic [3:0] rd, output logic [15:0] d,
                              output logic e, output int lat);
        bit got;
        got = 1'b0;
        rd = 'x; d = 'x; e = 'x; lat = -1;
        for (int i = 0; i < 300 && !got; i++) begin
            @(negedge clk);
            if (wb_valid) begin
                got = 1'b1;
                rd = wb_rd; d = wb_data; e = wb_err; lat = cyc - t0;
            end
        end
        if (got) begin
            wb_ready = 1'b1;
            @(posedge clk);
            #1;
            wb_ready = 1'b0;
            $display("wb rd=%0d data=%h err=%b lat=%0d", rd, d, e, lat);
        end else begin
            n_checks++; n_fail++;
            $display("FAIL wb_wait: wb_valid never rose, required within 300 cycles");
        end
    endtask

    task automatic test_reset();
        int ok_cnt;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++; if ({req_ready, fpu_en, wb_valid} !== 3'b000) begin n_fail++;
            $display("FAIL reset_outputs: ready/en/valid=%b required 000", {req_ready, fpu_en, wb_valid}); end
        n_checks++; if ({wb_data, wb_rd, wb_err} !== 21'h0) begin n_fail++;
            $display("FAIL reset_payload: got %h/%h/%b required 0", wb_data, wb_rd, wb_err); end
        n_checks++; if (busy !== 1'b1) begin n_fail++;
            $display("FAIL reset_busy: got %b required 1", busy); end
        @(posedge clk);
        #1 reset = 1'b0;
        ok_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (fpu_en === 1'b1 && fpu_instr === OPFTOI && fpu_op1 === 16'h0 && fpu_op2 === 16'h0
                && req_ready === 1'b1 && busy === 1'b1 && wb_valid === 1'b0) ok_cnt++;
        end
        n_checks++; if (ok_cnt != 3) begin n_fail++;
            $display("FAIL flush_cycles: got %0d good flush cycles required 3", ok_cnt); end
        @(negedge clk);
        n_checks++; if ({fpu_en, busy} !== 2'b00) begin n_fail++;
            $display("FAIL after_flush: en/busy=%b required 00", {fpu_en, busy}); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_latency();
        int t, lat;
        logic [3:0] rd;
        logic [15:0] d;
        logic e;
        push(OPITOF, 4'd3, 16'h1111, 16'h0028, t);
        get_result(t, rd, d, e, lat);
        n_checks++; if ({rd, d, e} !== {4'd3, 16'h4220, 1'b0}) begin n_fail++;
            $display("FAIL itof_40: got rd=%0d data=%h err=%b required rd=3 data=4220 err=0", rd, d, e); end
        n_checks++; if (lat != 5) begin n_fail++;
            $display("FAIL itof_40_latency: got %0d required 5", lat); end
    endtask

    task automatic test_back_to_back();
        int ta, tb, lat_a, lat_b, e0;
        logic [3:0] rd_a, rd_b;
        logic [15:0] d_a, d_b;
        logic e_a, e_b;
        e0 = itof_en_edges;
        push(OPITOF, 4'd1, 16'h0, 16'h0000, ta);
        push(OPITOF, 4'd2, 16'h0, 16'hFFFF, tb);
        get_result(ta, rd_a, d_a, e_a, lat_a);
        get_result(tb, rd_b, d_b, e_b, lat_b);
        n_checks++; if ({rd_a, d_a, e_a} !== {4'd1, 16'h0000, 1'b0}) begin n_fail++;
            $display("FAIL b2b_first: got rd=%0d data=%h err=%b required rd=1 data=0000 err=0", rd_a, d_a, e_a); end
        n_checks++; if (lat_a != 3) begin n_fail++;
            $display("FAIL b2b_zero_latency: got %0d required 3", lat_a); end
        n_checks++; if ({rd_b, d_b, e_b} !== {4'd2, 16'hBF80, 1'b0}) begin n_fail++;
            $display("FAIL b2b_second: got rd=%0d data=%h err=%b required rd=2 data=bf80 err=0", rd_b, d_b, e_b); end
        n_checks++; if (itof_en_edges - e0 != 4) begin n_fail++;
            $display("FAIL b2b_en_edges: got %0d enabled fpu edges required 4", itof_en_edges - e0); end
    endtask

    task automatic test_backpressure();
        int t, t4, rdy_cnt, lat;
        logic [3:0] rd [4];
        logic [15:0] d [4];
        logic e [4];
        logic [15:0] want [4];
        want[0] = 16'h3F80; want[1] = 16'h4000; want[2] = 16'h4040; want[3] = 16'h4080;
        wb_ready = 1'b0;
        push(OPITOF, 4'd1, 16'h0, 16'd1, t);
        push(OPITOF, 4'd2, 16'h0, 16'd2, t);
        push(OPITOF, 4'd3, 16'h0, 16'd3, t);
        rdy_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (req_ready) rdy_cnt++;
        end
        n_checks++; if (rdy_cnt != 0) begin n_fail++;
            $display("FAIL bp_ready_low: req_ready high %0d cycles required 0", rdy_cnt); end
        n_checks++; if ({wb_valid, wb_data, wb_rd} !== {1'b1, 16'h3F80, 4'd1}) begin n_fail++;
            $display("FAIL bp_hold: got valid=%b data=%h rd=%0d required 1/3f80/1", wb_valid, wb_data, wb_rd); end
        @(posedge clk);
        #1;
        fork
            push(OPITOF, 4'd4, 16'h0, 16'd4, t4);
            for (int k = 0; k < 4; k++) get_result(0, rd[k], d[k], e[k], lat);
        join
        for (int k = 0; k < 4; k++) begin
            n_checks++; if ({rd[k], d[k], e[k]} !== {4'(k + 1), want[k], 1'b0}) begin n_fail++;
                $display("FAIL bp_order_%0d: got rd=%0d data=%h err=%b required rd=%0d data=%h err=0",
                         k, rd[k], d[k], e[k], k + 1, want[k]); end
        end
    endtask

    task automatic test_illegal();
        int t, lat, o0;
        logic [3:0] rd;
        logic [15:0] d;
        logic e;
        o0 = other_en_edges;
        push(OPADD, 4'd7, 16'(($urandom)), 16'(($urandom)), t);
        get_result(t, rd, d, e, lat);
        n_checks++; if ({rd, d, e} !== {4'd7, 16'h0, 1'b1}) begin n_fail++;
            $display("FAIL illegal_payload: got rd=%0d data=%h err=%b required rd=7 data=0000 err=1", rd, d, e); end
        n_checks++; if (lat != 1) begin n_fail++;
            $display("FAIL illegal_latency: got %0d required 1", lat); end
        n_checks++; if (other_en_edges != o0) begin n_fail++;
            $display("FAIL illegal_no_launch: got %0d enabled edges required 0", other_en_edges - o0); end
        push(OPITOF, 4'd2, 16'h0, 16'h0028, t);
        get_result(t, rd, d, e, lat);
        n_checks++; if ({rd, d, e} !== {4'd2, 16'h4220, 1'b0}) begin n_fail++;
            $display("FAIL after_illegal: got rd=%0d data=%h err=%b required rd=2 data=4220 err=0", rd, d, e); end
    endtask

    task automatic test_reset_mid();
        int t, lat, ok_cnt, v_cnt;
        logic [3:0] rd;
        logic [15:0] d;
        logic e;
        push(OPITOF, 4'd5, 16'h0, 16'h0028, t);
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        n_checks++; if ({fpu_en, req_ready, wb_valid} !== 3'b000) begin n_fail++;
            $display("FAIL midreset_outputs: en/ready/valid=%b required 000", {fpu_en, req_ready, wb_valid}); end
        @(posedge clk);
        #1 reset = 1'b0;
        ok_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (fpu_en === 1'b1 && fpu_instr === OPFTOI) ok_cnt++;
        end
        n_checks++; if (ok_cnt != 3) begin n_fail++;
            $display("FAIL midreset_flush: got %0d flush cycles required 3", ok_cnt); end
        v_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (wb_valid !== 1'b0) v_cnt++;
        end
        n_checks++; if (v_cnt != 0 || busy !== 1'b0) begin n_fail++;
            $display("FAIL midreset_discard: wb_valid high %0d cycles busy=%b required 0/0", v_cnt, busy); end
        @(posedge clk);
        #1;
        push(OPITOF, 4'd6, 16'h0, 16'h0005, t);
        get_result(t, rd, d, e, lat);
        n_checks++; if ({rd, d, e} !== {4'd6, 16'h40A0, 1'b0}) begin n_fail++;
            $display("FAIL midreset_next: got rd=%0d data=%h err=%b required rd=6 data=40a0 err=0", rd, d, e); end
    endtask

    task automatic test_timeout();
        int t, lat;
        logic [3:0] rd;
        logic [15:0] d;
        logic e;
`ifdef FPU_TIMEOUT_EN
        int ok_cnt;
        push(OPMULF, 4'd9, 16'h1234, 16'h4321, t);
        get_result(t, rd, d, e, lat);
        n_checks++; if ({rd, d, e} !== {4'd9, 16'h0, 1'b1}) begin n_fail++;
            $display("FAIL timeout_payload: got rd=%0d data=%h err=%b required rd=9 data=0000 err=1", rd, d, e); end
        n_checks++; if (lat != 10) begin n_fail++;
            $display("FAIL timeout_latency: got %0d required 10", lat); end
        ok_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (fpu_en === 1'b1 && fpu_instr === OPFTOI) ok_cnt++;
        end
        n_checks++; if (ok_cnt != 3) begin n_fail++;
            $display("FAIL timeout_flush: got %0d flush cycles required 3", ok_cnt); end
        @(posedge clk);
        #1;
`else
        int b_cnt, v_cnt;
        push(OPMULF, 4'd9, 16'h1234, 16'h4321, t);
        b_cnt = 0;
        v_cnt = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (busy === 1'b1) b_cnt++;
            if (wb_valid !== 1'b0) v_cnt++;
        end
        n_checks++; if (b_cnt != 100 || v_cnt != 0) begin n_fail++;
            $display("FAIL hang_busy: busy %0d/100 cycles wb_valid %0d cycles required 100/0", b_cnt, v_cnt); end
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
`endif
        push(OPITOF, 4'd10, 16'h0, 16'h0028, t);
        get_result(t, rd, d, e, lat);
        n_checks++; if ({rd, d, e} !== {4'd10, 16'h4220, 1'b0}) begin n_fail++;
            $display("FAIL recover_itof: got rd=%0d data=%h err=%b required rd=10 data=4220 err=0", rd, d, e); end
    endtask

    task automatic test_random();
        localparam int N = 30;
        int got;
        got = 0;
        exp_q.delete();
        fork
            begin
                for (int i = 0; i < N; i++) begin
                    logic [4:0] op;
                    logic [3:0] rd;
                    logic [15:0] a, b;
                    int t;
                    exp_t x;
                    repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
                    if ($urandom_range(0, 9) < 6) op = OPITOF;
                    else begin
                        op = 5'($urandom_range(0, 25));
                        if (op >= 5'h11) op = op + 5'd6;
                    end
                    rd = 4'($urandom);
                    a  = 16'($urandom);
                    b  = ($urandom_range(0, 4) == 0) ? 16'h0 : 16'($urandom);
                    push(op, rd, a, b, t);
                    x.rd   = rd;
                    x.data = (op == OPITOF) ? itof(b) : 16'h0;
                    x.err  = (op != OPITOF);
                    if (t >= 0) exp_q.push_back(x);
                end
            end
            begin
                for (int c = 0; c < 5000 && got < N; c++) begin
                    @(posedge clk);
                    #1 wb_ready = 1'($urandom_range(0, 1));
                    @(negedge clk);
                    if (wb_valid && wb_ready) begin
                        exp_t x;
                        got++;
                        if (exp_q.size() == 0) begin
                            n_checks++; n_fail++;
                            $display("FAIL rand_extra: unexpected result rd=%0d data=%h, required none", wb_rd, wb_data);
                        end else begin
                            x = exp_q.pop_front();
                            $display("wb rd=%0d data=%h err=%b (random)", wb_rd, wb_data, wb_err);
                            n_checks++; if ({wb_rd, wb_data, wb_err} !== {x.rd, x.data, x.err}) begin n_fail++;
                                $display("FAIL rand_result_%0d: got rd=%0d data=%h err=%b required rd=%0d data=%h err=%b",
                                         got, wb_rd, wb_data, wb_err, x.rd, x.data, x.err); end
                        end
                    end
                end
                @(posedge clk);
                #1 wb_ready = 1'b0;
            end
        join
        n_checks++; if (got != N) begin n_fail++;
            $display("FAIL rand_count: got %0d results required %0d", got, N); end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_back_to_back();
        test_backpressure();
        test_illegal();
        test_reset_mid();
        test_timeout();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end
endmodule
